// File: rtl/threshold_sequencer_pkg.sv
// Shared phase encodings and offset limits for the adaptive-thresholding pipeline.
package threshold_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BOX    = 3'd1,
    ST_THRESH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd7
  } state_e;

  localparam int                 C_WIDTH = 5;
  localparam logic [C_WIDTH-1:0] C_MAX   = 5'd31;

  function automatic logic is_busy(input state_e s);
    return (s == ST_BOX) || (s == ST_THRESH);
  endfunction

endpackage

// File: rtl/threshold_sequencer_c_offset_reg.sv
// Saturating up/down register for the filter offset C; pulses outside en are dropped.
module c_offset_reg
  import threshold_sequencer_pkg::*;
#(
  parameter int C_DEFAULT = 2
) (
  input  logic               clock,
  input  logic               not_reset,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  output logic [C_WIDTH-1:0] c
);

  logic [C_WIDTH-1:0] c_q, c_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    c_d = c_q;
    if (en && inc && !dec && (c_q != C_MAX))
      c_d = c_q + C_WIDTH'(1);
    else if (en && dec && !inc && (c_q != '0))
      c_d = c_q - C_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) c_q <= C_DEFAULT[C_WIDTH-1:0];
    else            c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: rtl/threshold_sequencer.sv
// Phase controller: IDLE -> BOX -> THRESH -> DONE with per-phase timeout,
// busy-cycle counter, offset C ownership and middle-RAM read-port arbitration.
module threshold_sequencer
  import threshold_sequencer_pkg::*;
#(
  parameter int WIDTH_BITS     = 8,
  parameter int HEIGHT_BITS    = 8,
  parameter int C_DEFAULT      = 2,
  parameter int CNT_BITS       = 24,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iStart,
  input  logic                   iAbort,
  input  logic                   iCInc,
  input  logic                   iCDec,
  input  logic                   iBoxFinished,
  input  logic                   iThrFinished,
  output logic [2:0]             global_state,
  output logic [C_WIDTH-1:0]     C,
  output logic                   oBusy,
  output logic [CNT_BITS-1:0]    oCycles,
  input  logic [WIDTH_BITS-1:0]  iThrRdCol,
  input  logic [HEIGHT_BITS-1:0] iThrRdRow,
  input  logic [WIDTH_BITS-1:0]  iHostRdCol,
  input  logic [HEIGHT_BITS-1:0] iHostRdRow,
  output logic [WIDTH_BITS-1:0]  oRdCol,
  output logic [HEIGHT_BITS-1:0] oRdRow,
  output logic                   oHostGrant
);

  localparam int                  TMR_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic [CNT_BITS-1:0] cycles_q, cycles_d;
  logic                first_q, first_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic                fin;
  logic                c_en;

  // finished levels are stale during the first cycle of a phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOX:    fin = iBoxFinished && !first_q;
      ST_THRESH: fin = iThrFinished && !first_q;
      default:   fin = 1'b0;
    endcase
    if (iAbort)
      state_d = ST_IDLE;
    else if (is_busy(state_q)) begin
      if (fin) begin
        if (state_q == ST_BOX) state_d = ST_THRESH;
        else                   state_d = ST_DONE;
      end else if (tmr_q == TMR_LAST)
        state_d = ST_ERROR;
    end else if (iStart)
      state_d = ST_BOX;
  end

  always_comb begin
    first_d  = (state_d != state_q);
    tmr_d    = tmr_q;
    cycles_d = cycles_q;
    if (first_d)
      tmr_d = '0;
    else if (is_busy(state_q))
      tmr_d = tmr_q + TMR_BITS'(1);
    // A new run restarts the count; an aborting edge does not count.
    if ((state_d == ST_BOX) && (state_q != ST_BOX))
      cycles_d = '0;
    else if (is_busy(state_q) && !iAbort && (cycles_q != '1))
      cycles_d = cycles_q + CNT_BITS'(1);
    busy_d  = is_busy(state_d);
    grant_d = (state_d != ST_THRESH);
    c_en    = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      cycles_q <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cycles_q <= cycles_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
    end
  end

  c_offset_reg #(
    .C_DEFAULT (C_DEFAULT)
  ) u_c_offset (
    .clock     (clock),
    .not_reset (not_reset),
    .en        (c_en),
    .inc       (iCInc),
    .dec       (iCDec),
    .c         (C)
  );

  assign global_state = state_q;
  assign oBusy        = busy_q;
  assign oCycles      = cycles_q;
  assign oHostGrant   = grant_q;
  assign oRdCol       = grant_q ? iHostRdCol : iThrRdCol;
  assign oRdRow       = grant_q ? iHostRdRow : iThrRdRow;

endmodule

// File: tb/tb_threshold_sequencer.sv
// Bench for threshold_sequencer: phase sequencing, counter, C offset, timeout, arbitration, async reset.
module tb_threshold_sequencer;

  localparam int CNT_BITS = 6;
  localparam logic [2:0] S_IDLE = 3'd0, S_BOX = 3'd1, S_THRESH = 3'd2, S_DONE = 3'd3, S_ERROR = 3'd7;

  logic                clock, not_reset;
  logic                iStart, iAbort, iCInc, iCDec, iBoxFinished, iThrFinished;
  logic [2:0]          global_state;
  logic [4:0]          C;
  logic                oBusy;
  logic [CNT_BITS-1:0] oCycles;
  logic [7:0]          iThrRdCol, iThrRdRow, iHostRdCol, iHostRdRow, oRdCol, oRdRow;
  logic                oHostGrant;

  int errors = 0;
  int checks = 0;
  int c_exp  = 2;
  logic [2:0] exp_q[$];

  threshold_sequencer #(
    .WIDTH_BITS(8), .HEIGHT_BITS(8), .C_DEFAULT(2), .CNT_BITS(CNT_BITS), .TIMEOUT_CYCLES(64)
  ) dut (
    .clock(clock), .not_reset(not_reset), .iStart(iStart), .iAbort(iAbort),
    .iCInc(iCInc), .iCDec(iCDec), .iBoxFinished(iBoxFinished), .iThrFinished(iThrFinished),
    .global_state(global_state), .C(C), .oBusy(oBusy), .oCycles(oCycles),
    .iThrRdCol(iThrRdCol), .iThrRdRow(iThrRdRow), .iHostRdCol(iHostRdCol), .iHostRdRow(iHostRdRow),
    .oRdCol(oRdCol), .oRdRow(oRdRow), .oHostGrant(oHostGrant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    {iStart, iAbort, iCInc, iCDec, iBoxFinished, iThrFinished} = '0;
    iThrRdCol = 8'd5; iThrRdRow = 8'd9; iHostRdCol = 8'd200; iHostRdRow = 8'd17;
    not_reset = 1'b1;
    #2 not_reset = 1'b0;
    #1;
    checks++; if (global_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", global_state, S_IDLE); end
    checks++; if (C !== 5'd2) begin errors++; $display("FAIL reset_c: got %0d expected 2", C); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    checks++; if (oCycles !== '0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", oCycles); end
    checks++; if (oHostGrant !== 1'b1) begin errors++; $display("FAIL reset_grant: got %b expected 1", oHostGrant); end
    @(negedge clock);
    not_reset = 1'b1;
  endtask

  // Full run: BOX shown for b cycles, THRESH for t cycles.
  task automatic test_run(input int b, input int t, input int exp_cyc);
    logic [2:0] e;
    iStart = 1'b1; exp_q.push_back(S_BOX);
    @(negedge clock); iStart = 1'b0;
    e = exp_q.pop_front();
    checks++; if (global_state !== e) begin errors++; $display("FAIL run_start: got %0d expected %0d", global_state, e); end
    for (int k = 1; k <= b; k++) begin
      iBoxFinished = (k == b);
      exp_q.push_back((k == b) ? S_THRESH : S_BOX);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++; if (global_state !== e) begin errors++; $display("FAIL run_box k=%0d: got %0d expected %0d", k, global_state, e); end
    end
    iBoxFinished = 1'b0;
    for (int k = 1; k <= t; k++) begin
      iThrFinished = (k == t);
      exp_q.push_back((k == t) ? S_DONE : S_THRESH);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++; if (global_state !== e) begin errors++; $display("FAIL run_thr k=%0d: got %0d expected %0d", k, global_state, e); end
      checks++;
      if (e == S_THRESH) begin
        if (oRdCol !== 8'd5 || oRdRow !== 8'd9 || oHostGrant !== 1'b0) begin errors++;
          $display("FAIL arb_thresh: got %0d/%0d grant=%b expected 5/9 grant=0", oRdCol, oRdRow, oHostGrant); end
      end else begin
        if (oRdCol !== 8'd200 || oRdRow !== 8'd17 || oHostGrant !== 1'b1) begin errors++;
          $display("FAIL arb_done: got %0d/%0d grant=%b expected 200/17 grant=1", oRdCol, oRdRow, oHostGrant); end
      end
    end
    iThrFinished = 1'b0;
    checks++; if (oCycles !== CNT_BITS'(exp_cyc)) begin errors++; $display("FAIL run_cycles: got %0d expected %0d", oCycles, exp_cyc); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL run_busy_done: got %b expected 0", oBusy); end
  endtask

  task automatic test_stale_finished();
    logic [2:0] e;
    iBoxFinished = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iStart = (k == 0);
      exp_q.push_back((k == 2) ? S_THRESH : S_BOX);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++; if (global_state !== e) begin errors++; $display("FAIL stale k=%0d: got %0d expected %0d", k, global_state, e); end
    end
    iStart = 1'b0; iBoxFinished = 1'b0; iAbort = 1'b1;
    @(negedge clock); iAbort = 1'b0;
    checks++; if (global_state !== S_IDLE) begin errors++; $display("FAIL stale_abort: got %0d expected 0", global_state); end
    checks++; if (oCycles !== CNT_BITS'(2)) begin errors++; $display("FAIL abort_hold: got %0d expected 2", oCycles); end
  endtask

  task automatic test_c_offset();
    iCInc = 1'b1;
    for (int k = 0; k < 31; k++) begin
      @(negedge clock);
      if (c_exp < 31) c_exp++;
      checks++; if (C !== 5'(c_exp)) begin errors++; $display("FAIL c_inc k=%0d: got %0d expected %0d", k, C, c_exp); end
    end
    iCInc = 1'b0; iCDec = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (c_exp > 0) c_exp--;
      checks++; if (C !== 5'(c_exp)) begin errors++; $display("FAIL c_dec k=%0d: got %0d expected %0d", k, C, c_exp); end
    end
    iCDec = 1'b0; iCInc = 1'b1;
    repeat (3) @(negedge clock);
    c_exp = 3;
    iCDec = 1'b1;
    @(negedge clock);
    checks++; if (C !== 5'(c_exp)) begin errors++; $display("FAIL c_both: got %0d expected %0d", C, c_exp); end
    iCInc = 1'b0; iCDec = 1'b0; iStart = 1'b1;
    @(negedge clock); iStart = 1'b0; iCInc = 1'b1;
    @(negedge clock); iCInc = 1'b0;
    checks++; if (C !== 5'(c_exp) || global_state !== S_BOX) begin errors++;
      $display("FAIL c_in_box: got C=%0d st=%0d expected C=%0d st=1", C, global_state, c_exp); end
    iAbort = 1'b1;
    @(negedge clock); iAbort = 1'b0;
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    iStart = 1'b1;
    @(negedge clock); iStart = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      exp_q.push_back((k == 64) ? S_ERROR : S_BOX);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++; if (global_state !== e) begin errors++; $display("FAIL timeout k=%0d: got %0d expected %0d", k, global_state, e); end
    end
    checks++; if (oCycles !== '1 || oBusy !== 1'b0) begin errors++;
      $display("FAIL timeout_cycles: got %0d busy=%b expected 63 busy=0", oCycles, oBusy); end
    iCDec = 1'b1;
    @(negedge clock); iCDec = 1'b0; c_exp--;
    checks++; if (C !== 5'(c_exp)) begin errors++; $display("FAIL c_in_error: got %0d expected %0d", C, c_exp); end
    iStart = 1'b1;
    @(negedge clock); iStart = 1'b0;
    checks++; if (global_state !== S_BOX || oCycles !== '0) begin errors++;
      $display("FAIL error_restart: got st=%0d cyc=%0d expected st=1 cyc=0", global_state, oCycles); end
    iAbort = 1'b1;
    @(negedge clock);
    checks++; if (global_state !== S_IDLE) begin errors++; $display("FAIL abort_box: got %0d expected 0", global_state); end
    iStart = 1'b1;
    @(negedge clock); iAbort = 1'b0; iStart = 1'b0;
    checks++; if (global_state !== S_IDLE) begin errors++; $display("FAIL abort_wins: got %0d expected 0", global_state); end
    iStart = 1'b1;
    @(negedge clock); iStart = 1'b0;
    repeat (5) @(negedge clock);
    iAbort = 1'b1;
    @(negedge clock); iAbort = 1'b0;
    checks++; if (global_state !== S_IDLE || oCycles !== CNT_BITS'(5)) begin errors++;
      $display("FAIL abort_mid: got st=%0d cyc=%0d expected st=0 cyc=5", global_state, oCycles); end
  endtask

  task automatic test_async_reset();
    iCInc = 1'b1;
    @(negedge clock); iCInc = 1'b0;
    iStart = 1'b1;
    @(negedge clock); iStart = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      iBoxFinished = (k == 3);
      @(negedge clock);
    end
    iBoxFinished = 1'b0;
    checks++; if (global_state !== S_THRESH || C !== 5'(c_exp + 1)) begin errors++;
      $display("FAIL pre_reset: got st=%0d C=%0d expected st=2 C=%0d", global_state, C, c_exp + 1); end
    @(posedge clock);
    #2 not_reset = 1'b0;
    #1;
    checks++; if (global_state !== S_IDLE || C !== 5'd2 || oBusy !== 1'b0 || oCycles !== '0 || oHostGrant !== 1'b1) begin errors++;
      $display("FAIL async_reset: got st=%0d C=%0d busy=%b cyc=%0d grant=%b", global_state, C, oBusy, oCycles, oHostGrant); end
    checks++; if (oRdCol !== 8'd200 || oRdRow !== 8'd17) begin errors++;
      $display("FAIL async_reset_rd: got %0d/%0d expected 200/17", oRdCol, oRdRow); end
    @(negedge clock);
    not_reset = 1'b1;
    c_exp = 2;
  endtask

  initial begin
    test_reset();
    test_run(20, 15, 35);
    test_run(60, 40, 63);
    test_stale_finished();
    test_c_offset();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
